// File: rtl/tt_logic_cell.sv
// tt_logic_cell: runtime-reprogrammable N_IN-input truth-table cell.
// Inputs come in through a valid/ready handshake. Each result leaves through a
// single registered valid/ready stage. A serial configuration port fills a
// shadow table one bit at a time. The shadow replaces the active table
// atomically on a well-formed load.
// Optional feature macro: TT_PARITY_EN. When it is defined, every load carries
// one trailing even-parity bit over the table bits.
module tt_logic_cell #(
  parameter int unsigned          N_IN       = 4,
  parameter logic [(1<<N_IN)-1:0] DEFAULT_TT = 16'h0018
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_data,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  input  logic            cfg_last,
  output logic            cfg_done,
  output logic            cfg_err,
  output logic            loading
);

  localparam int unsigned TT_W = 1 << N_IN;
`ifdef TT_PARITY_EN
  localparam int unsigned LOAD_BITS = TT_W + 1;
`else
  localparam int unsigned LOAD_BITS = TT_W;
`endif
  localparam int unsigned CNT_W = $clog2(LOAD_BITS + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } cfg_state_e;

  // Configuration state
  cfg_state_e           state_q,  state_d;
  logic [LOAD_BITS-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic                 ovf_q,    ovf_d;
  logic [TT_W-1:0]      active_q, active_d;
  logic                 done_d;
  logic                 err_d;
  logic                 loading_d;

  // Working values for the bit being absorbed this cycle
  logic [CNT_W-1:0]     base_count_c;
  logic                 base_ovf_c;
  logic [CNT_W-1:0]     fill_count_c;
  logic                 fill_ovf_c;
  logic                 parity_ok_c;
  logic                 commit_ok_c;

  // Eval handshake
  logic                 accept_c;

  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  // Result register: latency 1, held stable under backpressure.
  // The lookup reads the active table as it stands before any commit on the
  // same edge, so an input accepted on a commit edge sees the old table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 1'b0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_data  <= active_q[in_data];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Config FSM next-state: absorb a bit, saturate the count, and run the
  // commit check on the last bit.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    active_d     = active_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    base_count_c = count_q;
    base_ovf_c   = ovf_q;
    fill_count_c = count_q;
    fill_ovf_c   = ovf_q;
    parity_ok_c  = 1'b1;
    commit_ok_c  = 1'b0;

    if (cfg_valid) begin
      // A bit that arrives in IDLE always starts a fresh load at index 0.
      if (state_q == S_IDLE) begin
        base_count_c = CNT_W'(0);
        base_ovf_c   = 1'b0;
      end

      fill_count_c = base_count_c;
      fill_ovf_c   = base_ovf_c;
      if (base_count_c < CNT_W'(LOAD_BITS)) begin
        for (int unsigned i = 0; i < LOAD_BITS; i++) begin
          if (CNT_W'(i) == base_count_c) begin
            shadow_d[i] = cfg_bit;
          end
        end
        fill_count_c = base_count_c + CNT_W'(1);
      end else begin
        // Bits beyond the full load length are dropped but poison the load.
        fill_ovf_c = 1'b1;
      end

`ifdef TT_PARITY_EN
      parity_ok_c = (shadow_d[LOAD_BITS-1] == (^shadow_d[TT_W-1:0]));
`endif

      if (cfg_last) begin
        commit_ok_c = (fill_count_c == CNT_W'(LOAD_BITS)) && !fill_ovf_c && parity_ok_c;
        if (commit_ok_c) begin
          active_d = shadow_d[TT_W-1:0];
          done_d   = 1'b1;
        end else begin
          err_d    = 1'b1;
        end
        state_d = S_IDLE;
        count_d = CNT_W'(0);
        ovf_d   = 1'b0;
      end else begin
        state_d = S_LOAD;
        count_d = fill_count_c;
        ovf_d   = fill_ovf_c;
      end
    end

    loading_d = (state_d == S_LOAD);
  end

  // Config FSM state and registered status outputs.
  // Reset clears a partial load silently, without an error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      active_q <= DEFAULT_TT;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      loading  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      active_q <= active_d;
      cfg_done <= done_d;
      cfg_err  <= err_d;
      loading  <= loading_d;
    end
  end

endmodule

// File: tb/tb_tt_logic_cell.sv
// Testbench for tt_logic_cell (N_IN = 4, default table 0x0018).
// A queue-based behavioural model is checked against the DUT on every cycle.
// Directed steps also pin the expected results with literal values.
`timescale 1ns/1ps
module tb_tt_logic_cell;

`ifdef TT_PARITY_EN
  localparam int LOAD_BITS = 17;
`else
  localparam int LOAD_BITS = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_data;
  logic       cfg_valid = 1'b0;
  logic       cfg_bit = 1'b0;
  logic       cfg_last = 1'b0;
  logic       cfg_done;
  logic       cfg_err;
  logic       loading;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Model state
  logic [15:0] m_tt      = 16'h0018;
  logic        m_ov      = 1'b0;
  logic        m_od      = 1'b0;
  logic        m_done    = 1'b0;
  logic        m_err     = 1'b0;
  logic        m_loading = 1'b0;
  bit          m_q[$];

  tt_logic_cell #(.N_IN(4), .DEFAULT_TT(16'h0018)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_last  (cfg_last),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .loading   (loading)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: the load is a list of received bits. It commits only when the list
  // is exactly one full load long and the parity (if enabled) holds.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_tt = 16'h0018; m_ov = 0; m_od = 0; m_done = 0; m_err = 0; m_loading = 0;
      m_q.delete();
    end else begin
      logic [15:0] nt;
      bit          ok;
      m_done = 0;
      m_err  = 0;
      if (in_valid && (!m_ov || out_ready)) begin
        m_ov = 1;
        m_od = m_tt[in_data];
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (cfg_valid) begin
        m_q.push_back(cfg_bit);
        m_loading = 1;
        if (cfg_last) begin
          ok = (m_q.size() == LOAD_BITS);
          nt = 16'h0;
          if (ok) begin
            for (int k = 0; k < 16; k++) nt[k] = m_q[k];
`ifdef TT_PARITY_EN
            if (m_q[16] != (^nt)) ok = 0;
`endif
          end
          if (ok) begin
            m_tt   = nt;
            m_done = 1;
          end else begin
            m_err = 1;
          end
          m_q.delete();
          m_loading = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (mon_en && !rst) begin
      chk("out_valid", out_valid, m_ov);
      chk("out_data",  out_data,  m_od);
      chk("in_ready",  in_ready,  !m_ov || out_ready);
      chk("loading",   loading,   m_loading);
      chk("cfg_done",  cfg_done,  m_done);
      chk("cfg_err",   cfg_err,   m_err);
      chk("done_err_excl", cfg_done & cfg_err, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic eval_one(input logic [3:0] d, input logic expv, input string nm);
    in_valid  = 1; in_data = d; out_ready = 1;
    tick();
    in_valid  = 0;
    chk(nm, out_data, expv);
  endtask

  // Serial load: table bits LSB first, then the parity bit, then zero filler.
  task automatic load(input logic [15:0] v, input int n, input logic flip_par, input logic eval_on_last);
    for (int k = 0; k < n; k++) begin
      cfg_valid = 1;
      if (k < 16)       cfg_bit = v[k];
      else if (k == 16) cfg_bit = (^v) ^ flip_par;
      else              cfg_bit = 0;
      cfg_last = (k == n - 1);
      if (eval_on_last && k == n - 1) begin
        in_valid = 1; in_data = 4'd0; out_ready = 1;
      end
      tick();
    end
    cfg_valid = 0; cfg_last = 0; cfg_bit = 0; in_valid = 0;
  endtask

  initial begin
    logic [3:0] seq_d [4];
    logic       seq_e [4];
    seq_d[0] = 4'd3; seq_d[1] = 4'd4; seq_d[2] = 4'd5; seq_d[3] = 4'd0;
    seq_e[0] = 1'b1; seq_e[1] = 1'b1; seq_e[2] = 1'b0; seq_e[3] = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_cfg_done",  cfg_done,  0);
    chk("rst_cfg_err",   cfg_err,   0);
    chk("rst_loading",   loading,   0);
    chk("rst_in_ready",  in_ready,  1);
    rst = 0;
    mon_en = 1;
    tick();

    // Back-to-back evaluation with the default table
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = seq_d[i];
      tick();
      chk("b2b_valid", out_valid, 1);
      chk("b2b_data",  out_data,  seq_e[i]);
    end
    in_valid = 0;
    tick();
    chk("b2b_drain", out_valid, 0);

    // Good load of 0x8000
    load(16'h8000, LOAD_BITS, 0, 0);
    chk("ld8000_done", cfg_done, 1);
    chk("ld8000_err",  cfg_err,  0);
    eval_one(4'd15, 1'b1, "tt8000_15");
    eval_one(4'd3,  1'b0, "tt8000_3");
    load(16'h0018, LOAD_BITS, 0, 0);
    chk("ld0018_done", cfg_done, 1);

    // An input accepted on the commit edge uses the old table
    load(16'hFFFF, LOAD_BITS, 0, 1);
    chk("atom_done", cfg_done, 1);
    chk("atom_old",  out_data, 0);
    eval_one(4'd0, 1'b1, "atom_new");
    load(16'h0018, LOAD_BITS, 0, 0);

    // Length errors leave the table untouched
    load(16'hFFFF, LOAD_BITS - 1, 0, 0);
    chk("short_err",  cfg_err,  1);
    chk("short_done", cfg_done, 0);
    eval_one(4'd0, 1'b0, "short_tt0");
    eval_one(4'd4, 1'b1, "short_tt4");
    load(16'hFFFF, LOAD_BITS + 4, 0, 0);
    chk("long_err",  cfg_err,  1);
    chk("long_done", cfg_done, 0);
    eval_one(4'd0, 1'b0, "long_tt0");
    tick();

    // Backpressure: the result is held and no new input is taken
    out_ready = 0; in_valid = 1; in_data = 4'd3;
    tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_data",  out_data,  1);
    in_data = 4'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", in_ready,  0);
      chk("bp_hold",  out_data,  1);
      chk("bp_hold_v", out_valid, 1);
    end
    out_ready = 1;
    tick();
    in_valid = 0;
    chk("bp_next_v", out_valid, 1);
    chk("bp_next_d", out_data,  0);
    tick();
    chk("bp_nodup", out_valid, 0);

    // Reset in the middle of a load
    for (int k = 0; k < 8; k++) begin
      cfg_valid = 1; cfg_bit = 1; cfg_last = 0;
      tick();
    end
    cfg_valid = 0; cfg_bit = 0;
    chk("mid_loading", loading, 1);
    rst = 1;
    #1;
    chk("mid_rst_loading", loading, 0);
    chk("mid_rst_err",     cfg_err, 0);
    tick();
    rst = 0;
    tick();
    chk("mid_after_err", cfg_err, 0);
    eval_one(4'd0, 1'b0, "mid_tt0");
    eval_one(4'd3, 1'b1, "mid_tt3");
    load(16'hFFFF, 8, 0, 0);
    chk("mid_partial_err", cfg_err, 1);

`ifdef TT_PARITY_EN
    load(16'h0018, 17, 0, 0);
    chk("par_good_done", cfg_done, 1);
    load(16'hFFFF, 17, 1, 0);
    chk("par_bad_err", cfg_err, 1);
    load(16'hFFFF, 16, 0, 0);
    chk("par_nopar_err", cfg_err, 1);
    eval_one(4'd0, 1'b0, "par_tt0");
`endif

    // Randomized traffic on both ports, checked cycle by cycle
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_bit   = 1'($urandom_range(0, 1));
      if (m_q.size() == LOAD_BITS - 1) cfg_last = ($urandom_range(0, 3) != 0);
      else                             cfg_last = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 599) == 0) rst = 1;
      tick();
      rst = 0;
    end
    in_valid = 0; cfg_valid = 0; cfg_last = 0; out_ready = 1;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
